// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: serialises CPU (port 0) and external master (port 1)
// accesses onto one memory port with fixed read latency, and stalls the CPU until its ack.
module dmem_arbiter #(
    parameter int unsigned AW           = 32,
    parameter int unsigned DW           = 32,
    parameter int unsigned MEM_LAT      = 2,
    parameter bit          CPU_PRIORITY = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic          cpu_stall,
    output logic          busy,
    output logic          grant_id,
    output logic          mem_read,
    output logic          mem_write,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state;
    logic          last_grant;
    logic          pick;
    logic [CW-1:0] lat_cnt;

    // Port chosen if a grant happens this cycle; ties go to port 0 or alternate.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = CPU_PRIORITY ? 1'b0 : ~last_grant;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    assign cpu_stall = req0 & ~ack0;

    // mem_addr/mem_wdata double as the latched request, so live inputs never reach memory.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            busy       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            lat_cnt    <= '0;
        end else begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        grant_id   <= pick;
                        last_grant <= pick;
                        mem_addr   <= pick ? addr1 : addr0;
                        mem_wdata  <= pick ? wdata1 : wdata0;
                        if (pick ? we1 : we0) begin
                            mem_write <= 1'b1;
                        end else begin
                            mem_read <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_write) begin
                        state <= RESP;
                        ack0  <= ~grant_id;
                        ack1  <= grant_id;
                    end else begin
                        lat_cnt <= CW'(MEM_LAT - 1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        if (grant_id) begin
                            rdata1 <= mem_rdata;
                        end else begin
                            rdata0 <= mem_rdata;
                        end
                        state <= RESP;
                        ack0  <= ~grant_id;
                        ack1  <= grant_id;
                    end else begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
